ctrl_word_pipe: RTL

Parametrised control-word register for the microprogrammed control unit. It sits between the microstore/encoder and the datapath, and captures the full control word plus the current state number each clock. It generalises single-stage latching to DEPTH stages and adds the following:
- stall (hold), e.g. while waiting on memory MOC
- flush to a NOP word
- a valid bit
- a saturating dwell counter with a timeout flag for stuck multi-cycle states

---
 rtl/ctrl_word_pipe_pkg.sv | 47 ++++
 rtl/ctrl_word_pipe_stage.sv | 33 +++
 rtl/ctrl_word_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/ctrl_word_pipe_pkg.sv
// Control-word layout shared by the microstore, the control-word pipe and the datapath.
// Field positions are fixed by the microcode format; consumers slice through ctrl_fields_t.
package ctrl_pkg;

    localparam int CW_W = 44;
    localparam int ST_W = 7;

    localparam logic [CW_W-1:0] NOP_WORD    = '0;
    localparam logic [ST_W-1:0] RESET_STATE = '0;

    localparam int IRLD_BIT  = 43;
    localparam int PCLD_BIT  = 42;
    localparam int NPCLD_BIT = 41;
    localparam int RFLD_BIT  = 40;
    localparam int MA_BIT    = 39;
    localparam int MB_MSB    = 38;
    localparam int MB_LSB    = 37;
    localparam int OPC_MSB   = 26;
    localparam int OPC_LSB   = 21;
    localparam int OP_MSB    = 17;
    localparam int OP_LSB    = 14;
    localparam int CR_MSB    = 13;
    localparam int CR_LSB    = 7;
    localparam int S_MSB     = 4;
    localparam int S_LSB     = 3;
    localparam int N_MSB     = 2;
    localparam int N_LSB     = 0;

    // Unnamed gaps in the format are kept as reserved fields so the struct stays CW_W wide.
    typedef struct packed {
        logic       irld;      // 43
        logic       pcld;      // 42
        logic       npcld;     // 41
        logic       rfld;      // 40
        logic       ma;        // 39
        logic [1:0] mb;        // 38:37
        logic [9:0] rsvd_hi;   // 36:27
        logic [5:0] opc;       // 26:21
        logic [2:0] rsvd_mid;  // 20:18
        logic [3:0] op;        // 17:14
        logic [6:0] cr;        // 13:7
        logic [1:0] rsvd_lo;   // 6:5
        logic [1:0] s;         // 4:3
        logic [2:0] n;         // 2:0
    } ctrl_fields_t;

endpackage

// File: rtl/ctrl_word_pipe_stage.sv
// One control-word register stage: clear to NOP, hold, or load; one cycle.
// Backpressure: hold freezes the stage; clear wins over hold.
module ctrl_stage #(
    parameter int                CW_W        = ctrl_pkg::CW_W,
    parameter int                ST_W        = ctrl_pkg::ST_W,
    parameter logic [CW_W-1:0]   NOP_WORD    = ctrl_pkg::NOP_WORD,
    parameter logic [ST_W-1:0]   RESET_STATE = ctrl_pkg::RESET_STATE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            hold,
    input  logic [CW_W-1:0] d_cw,
    input  logic [ST_W-1:0] d_state,
    input  logic            d_valid,
    output logic [CW_W-1:0] q_cw,
    output logic [ST_W-1:0] q_state,
    output logic            q_valid
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q_cw    <= NOP_WORD;
            q_state <= RESET_STATE;
            q_valid <= 1'b0;
        end else if (!hold) begin
            q_cw    <= d_cw;
            q_state <= d_state;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/ctrl_word_pipe.sv
// DEPTH-stage registered control word with flush-to-NOP, stall hold and a dwell/timeout watchdog.
// Latency DEPTH advancing edges; stall freezes every stage and the producer must hold its input.
module ctrl_word_pipe #(
    parameter int                CW_W        = ctrl_pkg::CW_W,
    parameter int                ST_W        = ctrl_pkg::ST_W,
    parameter int                DEPTH       = 1,
    parameter logic [CW_W-1:0]   NOP_WORD    = ctrl_pkg::NOP_WORD,
    parameter logic [ST_W-1:0]   RESET_STATE = ctrl_pkg::RESET_STATE,
    parameter int                CNT_W       = 8,
    parameter int                TIMEOUT     = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CW_W-1:0]  cw_in,
    input  logic [ST_W-1:0]  state_in,
    input  logic             valid_in,
    input  logic             stall,
    input  logic             flush,
    output logic [CW_W-1:0]  cw_out,
    output logic [ST_W-1:0]  state_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] dwell,
    output logic             timeout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("ctrl_word_pipe: DEPTH must be at least 1");
    end
    if (TIMEOUT < 1 || TIMEOUT > (2**CNT_W) - 1) begin : g_bad_timeout
        $error("ctrl_word_pipe: TIMEOUT must lie in 1 .. 2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [CW_W-1:0] stg_cw    [DEPTH];
    logic [ST_W-1:0] stg_state [DEPTH];
    logic            stg_valid [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [CW_W-1:0] d_cw;
        logic [ST_W-1:0] d_state;
        logic            d_valid;

        if (k == 0) begin : g_head
            // Substituting NOP here keeps an undriven cw_in out of the pipe on bubbles.
            assign d_cw    = valid_in ? cw_in : NOP_WORD;
            assign d_state = state_in;
            assign d_valid = valid_in;
        end else begin : g_body
            assign d_cw    = stg_cw[k-1];
            assign d_state = stg_state[k-1];
            assign d_valid = stg_valid[k-1];
        end

        ctrl_stage #(
            .CW_W        (CW_W),
            .ST_W        (ST_W),
            .NOP_WORD    (NOP_WORD),
            .RESET_STATE (RESET_STATE)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clear   (flush),
            .hold    (stall),
            .d_cw    (d_cw),
            .d_state (d_state),
            .d_valid (d_valid),
            .q_cw    (stg_cw[k]),
            .q_state (stg_state[k]),
            .q_valid (stg_valid[k])
        );
    end

    assign cw_out    = stg_cw[DEPTH-1];
    assign state_out = stg_state[DEPTH-1];
    assign valid_out = stg_valid[DEPTH-1];

    // Counts only while a real word is parked at the output; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            dwell <= '0;
        end else if (stall && valid_out) begin
            if (dwell != DWELL_MAX) begin
                dwell <= dwell + 1'b1;
            end
        end else begin
            dwell <= '0;
        end
    end

    assign timeout = (dwell >= TIMEOUT_C);

endmodule
